// File: rtl/adc_pkg.sv
// Shared constants for the ADC sample averager: controller data width,
// the controller's clamp code and the default window size.
package adc_pkg;

  localparam int ADC_DATA_W = 20;
  localparam int ADC_LOG2_N = 4;
  localparam logic [ADC_DATA_W-1:0] ADC_SAT_VAL = {ADC_DATA_W{1'b1}};
  localparam int N = 2**ADC_LOG2_N;

  // Samples per window for a given log2 window size.
  function automatic int win_size(input int log2_n);
    return 1 << log2_n;
  endfunction

endpackage

// File: rtl/adc_avg_out_buf.sv
// One-deep result register with valid/ready handshake. A new result loaded
// while the previous one is still pending and not being taken sets overrun.
module adc_avg_out_buf
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_avg,
  input  logic [DATA_W-1:0] load_min,
  input  logic [DATA_W-1:0] load_max,
  input  logic              clr_overrun,
  input  logic              ready,
  output logic [DATA_W-1:0] res_avg,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic              valid,
  output logic              overrun
);

  logic take;

  assign take = valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_avg <= '0;
      res_min <= '0;
      res_max <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        res_avg <= load_avg;
        res_min <= load_min;
        res_max <= load_max;
        valid   <= 1'b1;
      end else if (take) begin
        valid <= 1'b0;
      end

      // Flush and a window close never coincide, so the clear needs no priority rule.
      if (clr_overrun) begin
        overrun <= 1'b0;
      end else if (load && valid && !ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Averages fixed windows of 2**LOG2_N ADC conversions and tracks min/max.
// Optional macro ADC_AVG_SAT_REJECT_EN drops clamped (all-ones) samples and counts them.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LOG2_N = ADC_LOG2_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_vld,
  input  logic              flush,
  output logic [DATA_W-1:0] avg_data,
  output logic [DATA_W-1:0] avg_min,
  output logic [DATA_W-1:0] avg_max,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun,
  output logic [7:0]        sat_count
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int WIN   = win_size(LOG2_N);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIN - 1);
  localparam logic [DATA_W-1:0] SAT_CODE = {DATA_W{1'b1}};

  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] min_reg;
  logic [DATA_W-1:0] max_reg;

  logic              sample_ok;
  logic              take;
  logic              close;
  logic [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0] min_next;
  logic [DATA_W-1:0] max_next;

`ifdef ADC_AVG_SAT_REJECT_EN
  logic [7:0] sat_count_reg;

  assign sample_ok = (sample != SAT_CODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_reg <= '0;
    end else if (flush) begin
      sat_count_reg <= '0;
    end else if (sample_vld && !sample_ok && sat_count_reg != 8'hFF) begin
      sat_count_reg <= sat_count_reg + 8'd1;
    end
  end

  assign sat_count = sat_count_reg;
`else
  assign sample_ok = 1'b1;
  assign sat_count = '0;
`endif

  // A sample arriving with flush is discarded.
  assign take     = sample_vld & sample_ok & ~flush;
  assign close    = take & (cnt_reg == LAST_CNT);
  assign acc_next = acc_reg + ACC_W'(sample);
  assign min_next = (sample < min_reg) ? sample : min_reg;
  assign max_next = (sample > max_reg) ? sample : max_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      min_reg <= SAT_CODE;
      max_reg <= '0;
    end else if (flush || close) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      min_reg <= SAT_CODE;
      max_reg <= '0;
    end else if (take) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + CNT_W'(1);
      min_reg <= min_next;
      max_reg <= max_next;
    end
  end

  // The upper DATA_W bits of the accumulator are the truncated average.
  adc_avg_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (close),
    .load_avg    (acc_next[ACC_W-1:LOG2_N]),
    .load_min    (min_next),
    .load_max    (max_next),
    .clr_overrun (flush),
    .ready       (avg_ready),
    .res_avg     (avg_data),
    .res_min     (avg_min),
    .res_max     (avg_max),
    .valid       (avg_valid),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager with 4-sample windows; expectations
// follow ADC_AVG_SAT_REJECT_EN when the bench is built with that macro.
module tb_adc_sample_averager;

  localparam int DATA_W = 20;
  localparam int LOG2_N = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sample = '0;
  logic              sample_vld = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] avg_data;
  logic [DATA_W-1:0] avg_min;
  logic [DATA_W-1:0] avg_max;
  logic              avg_valid;
  logic              avg_ready = 1'b1;
  logic              overrun;
  logic [7:0]        sat_count;

  int checks = 0;
  int passes = 0;

  adc_sample_averager #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample     (sample),
    .sample_vld (sample_vld),
    .flush      (flush),
    .avg_data   (avg_data),
    .avg_min    (avg_min),
    .avg_max    (avg_max),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .overrun    (overrun),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle; returns at the negedge after capture.
  task automatic send(input logic [DATA_W-1:0] v);
    sample     = v;
    sample_vld = 1'b1;
    @(negedge clk);
    sample_vld = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(avg_valid), 32'd0);
    check("rst_data", 32'(avg_data), 32'd0);
    check("rst_min", 32'(avg_min), 32'd0);
    check("rst_max", 32'(avg_max), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sat", 32'(sat_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic window, result one cycle after the 4th eoc
    send(20'd100); send(20'd200); send(20'd300);
    check("t1_not_yet", 32'(avg_valid), 32'd0);
    send(20'd400);
    $display("t1 window: avg=%0d min=%0d max=%0d valid=%0b", avg_data, avg_min, avg_max, avg_valid);
    check("t1_valid", 32'(avg_valid), 32'd1);
    check("t1_avg", 32'(avg_data), 32'd250);
    check("t1_min", 32'(avg_min), 32'd100);
    check("t1_max", 32'(avg_max), 32'd400);
    @(negedge clk);
    check("t1_consumed", 32'(avg_valid), 32'd0);

    // 2: truncation and full-scale accumulation
    send(20'd1); send(20'd1); send(20'd1); send(20'd2);
    $display("t2 trunc: avg=%0d", avg_data);
    check("t2_trunc", 32'(avg_data), 32'd1);
    send(20'hFFFFE); send(20'hFFFFE); send(20'hFFFFE); send(20'hFFFFE);
    $display("t2 wide: avg=0x%0h", avg_data);
    check("t2_wide", 32'(avg_data), 32'hFFFFE);
    check("t2_wide_max", 32'(avg_max), 32'hFFFFE);
    @(negedge clk);

    // 3: overwrite while pending, then flush keeps the result
    avg_ready = 1'b0;
    send(20'd10); send(20'd10); send(20'd10); send(20'd10);
    check("t3_first_avg", 32'(avg_data), 32'd10);
    check("t3_no_ovr", 32'(overrun), 32'd0);
    send(20'd20); send(20'd20); send(20'd20); send(20'd20);
    $display("t3 overwrite: avg=%0d overrun=%0b valid=%0b", avg_data, overrun, avg_valid);
    check("t3_avg", 32'(avg_data), 32'd20);
    check("t3_overrun", 32'(overrun), 32'd1);
    do_flush();
    $display("t3 flush: avg=%0d overrun=%0b valid=%0b", avg_data, overrun, avg_valid);
    check("t3_flush_ovr", 32'(overrun), 32'd0);
    check("t3_flush_valid", 32'(avg_valid), 32'd1);
    check("t3_flush_data", 32'(avg_data), 32'd20);
    avg_ready = 1'b1;
    @(negedge clk);
    check("t3_drain", 32'(avg_valid), 32'd0);

    // 3b: close coinciding with a handshake reloads without overrun
    avg_ready = 1'b0;
    send(20'd7); send(20'd7); send(20'd7); send(20'd7);
    send(20'd9); send(20'd9); send(20'd9);
    avg_ready = 1'b1;
    send(20'd9);
    $display("t3b handshake+close: avg=%0d overrun=%0b valid=%0b", avg_data, overrun, avg_valid);
    check("t3b_valid", 32'(avg_valid), 32'd1);
    check("t3b_avg", 32'(avg_data), 32'd9);
    check("t3b_no_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    check("t3b_drain", 32'(avg_valid), 32'd0);

    // 4: flush with a same-cycle sample discards the partial window
    send(20'd50); send(20'd60);
    flush = 1'b1;
    send(20'd999);
    flush = 1'b0;
    send(20'd8); send(20'd8); send(20'd8);
    check("t4_no_early", 32'(avg_valid), 32'd0);
    send(20'd8);
    $display("t4 after flush: avg=%0d min=%0d max=%0d", avg_data, avg_min, avg_max);
    check("t4_avg", 32'(avg_data), 32'd8);
    check("t4_min", 32'(avg_min), 32'd8);
    check("t4_max", 32'(avg_max), 32'd8);
    @(negedge clk);

    // 5: async reset mid-window loses the partial state
    send(20'd100); send(20'd100); send(20'd100);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", 32'(avg_valid), 32'd0);
    check("t5_rst_data", 32'(avg_data), 32'd0);
    send(20'd5); send(20'd5); send(20'd5);
    check("t5_no_early", 32'(avg_valid), 32'd0);
    send(20'd5);
    $display("t5 after rst: avg=%0d min=%0d max=%0d", avg_data, avg_min, avg_max);
    check("t5_avg", 32'(avg_data), 32'd5);
    check("t5_min", 32'(avg_min), 32'd5);
    check("t5_max", 32'(avg_max), 32'd5);
    @(negedge clk);

    // 6: saturated-sample handling
`ifdef ADC_AVG_SAT_REJECT_EN
    send(20'd4); send(20'hFFFFF); send(20'd4); send(20'd4);
    check("t6_not_yet", 32'(avg_valid), 32'd0);
    send(20'd4);
    $display("t6 reject: avg=0x%0h sat=%0d", avg_data, sat_count);
    check("t6_avg", 32'(avg_data), 32'd4);
    check("t6_max", 32'(avg_max), 32'd4);
    check("t6_sat", 32'(sat_count), 32'd1);
    do_flush();
    check("t6_sat_flush", 32'(sat_count), 32'd0);
`else
    send(20'd4); send(20'hFFFFF); send(20'd4); send(20'd4);
    $display("t6 no reject: avg=0x%0h sat=%0d", avg_data, sat_count);
    check("t6_avg", 32'(avg_data), 32'h40002);
    check("t6_max", 32'(avg_max), 32'hFFFFF);
    check("t6_min", 32'(avg_min), 32'd4);
    check("t6_sat", 32'(sat_count), 32'd0);
    do_flush();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
